// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: sync, data-enable and pixel coordinates.
// Optional 16-bit frame counter output is enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC_W   = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC_W   = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned H_CNT_W    = 10,
  parameter int unsigned V_CNT_W    = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PIX_EN,
  output logic               H_SYNC,
  output logic               V_SYNC,
  output logic               DE,
  output logic [H_CNT_W-1:0] PIX_X,
  output logic [V_CNT_W-1:0] PIX_Y,
  output logic               LINE_START,
  output logic               FRAME_START
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]        FRAME_CNT
`endif
);

  localparam int unsigned HTotal     = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
  localparam int unsigned VTotal     = V_ACTIVE + V_FP + V_SYNC_W + V_BP;
  localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC_W;
  localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC_W;

  // Reject zero-sized regions and totals that overflow their counters.
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC_W == 0 || H_BP == 0 ||
      H_CNT_W == 0 || H_CNT_W > 31 || HTotal > (32'd1 << H_CNT_W)) begin : gen_h_cfg_err
    $error("vga_timing_gen: invalid horizontal configuration");
  end
  if (V_ACTIVE == 0 || V_FP == 0 || V_SYNC_W == 0 || V_BP == 0 ||
      V_CNT_W == 0 || V_CNT_W > 31 || VTotal > (32'd1 << V_CNT_W)) begin : gen_v_cfg_err
    $error("vga_timing_gen: invalid vertical configuration");
  end

  // Back porch is at least one, so every boundary below fits the counter width.
  localparam logic [H_CNT_W-1:0] HMax    = H_CNT_W'(HTotal - 1);
  localparam logic [H_CNT_W-1:0] HAct    = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HSyncLo = H_CNT_W'(HSyncStart);
  localparam logic [H_CNT_W-1:0] HSyncHi = H_CNT_W'(HSyncEnd);
  localparam logic [V_CNT_W-1:0] VMax    = V_CNT_W'(VTotal - 1);
  localparam logic [V_CNT_W-1:0] VAct    = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VSyncLo = V_CNT_W'(VSyncStart);
  localparam logic [V_CNT_W-1:0] VSyncHi = V_CNT_W'(VSyncEnd);

  logic [H_CNT_W-1:0] h_q, h_d;
  logic [V_CNT_W-1:0] v_q, v_d;
  logic               de_q, de_d;
  logic               h_sync_q, h_sync_d;
  logic               v_sync_q, v_sync_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (PIX_EN) begin
      if (h_q == HMax) begin
        h_d = '0;
        v_d = (v_q == VMax) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Outputs decode the next count so they line up with PIX_X/PIX_Y after the edge.
  always_comb begin
    de_d          = (h_d < HAct) && (v_d < VAct);
    h_sync_d      = ((h_d >= HSyncLo) && (h_d < HSyncHi)) ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_d      = ((v_d >= VSyncLo) && (v_d < VSyncHi)) ? V_SYNC_POL : ~V_SYNC_POL;
    line_start_d  = PIX_EN && (h_q == HMax);
    frame_start_d = PIX_EN && (h_q == HMax) && (v_q == VMax);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_q           <= HMax;
      v_q           <= VMax;
      de_q          <= 1'b0;
      h_sync_q      <= ~H_SYNC_POL;
      v_sync_q      <= ~V_SYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      de_q          <= de_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign PIX_X       = h_q;
  assign PIX_Y       = v_q;
  assign DE          = de_q;
  assign H_SYNC      = h_sync_q;
  assign V_SYNC      = v_sync_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign FRAME_CNT = frame_cnt_q;
`endif

endmodule
